// File: rtl/rgb565_gray_stage.sv
// Drains an RGB565 pixel FIFO, converts each pixel to 8-bit luma and presents
// it on a valid/ready stream tagged with raster coordinates and frame markers.
module rgb565_gray_stage #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_empty,
    output logic                     fifo_rden,
    input  logic [15:0]              fifo_data,
    input  logic                     frame_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_gray,
    output logic [$clog2(IMG_W)-1:0] out_x,
    output logic [$clog2(IMG_H)-1:0] out_y,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     out_eof
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [7:0]    buf_q [2];
    logic          rd_ptr_q;
    logic          wr_ptr_q;
    logic [1:0]    occ_q;
    logic [1:0]    occ_d;
    logic          inflight_q;
    logic [XW-1:0] x_q;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_q;
    logic [YW-1:0] y_d;

    logic          push;
    logic          pop;
    logic [1:0]    committed;
    logic [7:0]    r8;
    logic [7:0]    g8;
    logic [7:0]    b8;
    logic [15:0]   luma_sum;
    logic [7:0]    gray;

    // Channel expansion replicates the MSBs so full-scale maps to 255.
    assign r8       = {fifo_data[15:11], fifo_data[15:13]};
    assign g8       = {fifo_data[10:5],  fifo_data[10:9]};
    assign b8       = {fifo_data[4:0],   fifo_data[4:2]};
    assign luma_sum = 16'(r8) * 16'd77 + 16'(g8) * 16'd150 + 16'(b8) * 16'd29;
    assign gray     = 8'(luma_sum >> 8);

    assign out_valid = (occ_q != 2'd0);
    assign out_gray  = buf_q[rd_ptr_q];
    assign pop       = out_valid && out_ready;
    assign push      = inflight_q;

    // Slots already spoken for once this cycle's handshake retires; never exceeds 2.
    assign committed = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    assign fifo_rden = !rst && !fifo_empty && (committed < 2'd2);

    assign out_x   = x_q;
    assign out_y   = y_q;
    assign out_sof = out_valid && (x_q == '0) && (y_q == '0);
    assign out_eol = out_valid && (x_q == X_LAST);
    assign out_eof = out_valid && (x_q == X_LAST) && (y_q == Y_LAST);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        x_d   = x_q;
        y_d   = y_q;
        if (frame_clr) begin
            x_d = '0;
            y_d = '0;
        end else if (pop) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the buffer is reset because out_gray must read 0 out of reset.
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            inflight_q <= fifo_rden;
            occ_q      <= occ_d;
            x_q        <= x_d;
            y_q        <= y_d;
            if (push) begin
                buf_q[wr_ptr_q] <= gray;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_rgb565_gray_stage.sv
// Scoreboard bench for rgb565_gray_stage: a registered FIFO model feeds the DUT,
// expected luma values queue at each pop and are compared at each handshake.
module tb_rgb565_gray_stage;

    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rden;
    logic [15:0]   fifo_data;
    logic          frame_clr;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_gray;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;

    rgb565_gray_stage #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rden  (fifo_rden),
        .fifo_data  (fifo_data),
        .frame_clr  (frame_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gray   (out_gray),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_eof    (out_eof)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pix;
        logic [7:0]  gray;
    } item_t;

    item_t      src_q[$];
    logic [7:0] exp_q[$];
    int         x_log[$];
    int         y_log[$];
    int         sof_log[$];
    int         eol_log[$];
    int         eof_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mx       = 0;
    int my       = 0;
    int rden_first, rden_last, rden_cnt;
    int valid_first, valid_last, valid_cnt;
    int hs_cnt;
    int clr_hits;
    bit auto_clr;
    bit expect_origin;
    logic [7:0] first_gray;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        n_checks++;
        if (got !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, expected);
        end
    endtask

    function automatic logic [7:0] gray_model(input logic [15:0] p);
        int r;
        int g;
        int b;
        r = int'({p[15:11], p[15:13]});
        g = int'({p[10:5], p[10:9]});
        b = int'({p[4:0], p[4:2]});
        return 8'((77 * r + 150 * g + 29 * b) / 256);
    endfunction

    task automatic load_exp(input logic [15:0] pix, input logic [7:0] g);
        item_t it;
        it.pix  = pix;
        it.gray = g;
        src_q.push_back(it);
        fifo_empty = 1'b0;
    endtask

    task automatic load(input logic [15:0] pix);
        load_exp(pix, gray_model(pix));
    endtask

    task automatic reset_trackers();
        rden_first  = -1;
        rden_last   = -1;
        rden_cnt    = 0;
        valid_first = -1;
        valid_last  = -1;
        valid_cnt   = 0;
        hs_cnt      = 0;
        x_log.delete();
        y_log.delete();
        sof_log.delete();
        eol_log.delete();
        eof_log.delete();
    endtask

    // One clock: sample at the falling edge, then advance the FIFO model after the rising edge.
    task automatic cycle();
        logic popped;
        item_t it;
        @(negedge clk);
        if (auto_clr && out_valid && out_ready && out_x == XW'(1) && out_y == YW'(1))
            frame_clr = 1'b1;
        if (fifo_rden) begin
            rden_cnt++;
            if (rden_first < 0) rden_first = cyc;
            rden_last = cyc;
        end
        if (out_valid) begin
            valid_cnt++;
            if (valid_first < 0) valid_first = cyc;
            valid_last = cyc;
        end else begin
            check("idle_flags", {out_sof, out_eol, out_eof}, 3'b000);
        end
        if (fifo_rden && fifo_empty) check("rden_while_empty", 1, 0);
        if (out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_pixel", 1, 0);
            end else begin
                check("gray", out_gray, exp_q.pop_front());
            end
            check("x", out_x, mx);
            check("y", out_y, my);
            check("sof", out_sof, (mx == 0 && my == 0));
            check("eol", out_eol, (mx == IMG_W - 1));
            check("eof", out_eof, (mx == IMG_W - 1 && my == IMG_H - 1));
            if (expect_origin) begin
                check("clr_sof", out_sof, 1);
                check("clr_xy", {out_y, out_x}, 0);
                expect_origin = 1'b0;
            end
            x_log.push_back(int'(out_x));
            y_log.push_back(int'(out_y));
            sof_log.push_back(int'(out_sof));
            eol_log.push_back(int'(out_eol));
            eof_log.push_back(int'(out_eof));
            if (mx == IMG_W - 1) begin
                mx = 0;
                my = (my == IMG_H - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
        if (frame_clr) begin
            mx = 0;
            my = 0;
            if (auto_clr) begin
                clr_hits++;
                expect_origin = 1'b1;
                auto_clr      = 1'b0;
            end
        end
        popped = fifo_rden && !fifo_empty;
        @(posedge clk);
        #1;
        frame_clr = 1'b0;
        if (popped && src_q.size() > 0) begin
            it        = src_q.pop_front();
            fifo_data = it.pix;
            exp_q.push_back(it.gray);
        end
        fifo_empty = (src_q.size() == 0);
        cyc++;
    endtask

    task automatic drain(input int max_cyc, input string tag);
        int n;
        n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0 || out_valid) && n < max_cyc) begin
            cycle();
            n++;
        end
        check({tag, "_drained"}, (n < max_cyc), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        fifo_empty    = 1'b1;
        fifo_data     = '0;
        frame_clr     = 1'b0;
        out_ready     = 1'b0;
        auto_clr      = 1'b0;
        expect_origin = 1'b0;
        clr_hits      = 0;
        reset_trackers();

        // Reset state, with data already waiting in the FIFO.
        load_exp(16'hFFFF, 8'd255);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_rden", fifo_rden, 0);
        check("rst_gray", out_gray, 0);
        check("rst_xy", {out_y, out_x}, 0);
        check("rst_flags", {out_sof, out_eol, out_eof}, 3'b000);
        rst = 1'b0;

        // Conversion of the primaries and latency of the first pixel.
        load_exp(16'hF800, 8'd76);
        load_exp(16'h07E0, 8'd149);
        load_exp(16'h001F, 8'd28);
        load_exp(16'h0000, 8'd0);
        out_ready = 1'b1;
        drain(40, "conv");
        check("conv_latency", valid_first - rden_first, 2);
        check("conv_count", hs_cnt, 5);

        // Continuous streaming: no gaps on either side.
        reset_trackers();
        for (int i = 0; i < 8; i++) load(16'($urandom_range(0, 65535)));
        drain(40, "stream");
        check("stream_rden_cnt", rden_cnt, 8);
        check("stream_rden_span", rden_last - rden_first + 1, 8);
        check("stream_valid_cnt", valid_cnt, 8);
        check("stream_valid_span", valid_last - valid_first + 1, 8);
        check("stream_count", hs_cnt, 8);

        // Backpressure: two pops fill the buffer, head stays frozen.
        reset_trackers();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(16'h1234 + 16'(i * 16'h0F1D));
        first_gray = gray_model(16'h1234);
        repeat (6) cycle();
        check("bp_pops", rden_cnt, 2);
        check("bp_rden_now", fifo_rden, 0);
        check("bp_valid", out_valid, 1);
        check("bp_head", out_gray, first_gray);
        check("bp_src_left", src_q.size(), 3);
        out_ready = 1'b1;
        drain(40, "bp");
        check("bp_count", hs_cnt, 5);

        // Raster tags on a 4x3 frame, 13 pixels.
        frame_clr = 1'b1;
        cycle();
        reset_trackers();
        for (int i = 0; i < 13; i++) load(16'($urandom_range(0, 65535)));
        drain(60, "raster");
        check("raster_count", sof_log.size(), 13);
        if (sof_log.size() == 13) begin
            for (int i = 0; i < 13; i++) begin
                check($sformatf("raster_sof_%0d", i), sof_log[i], (i == 0 || i == 12));
                check($sformatf("raster_eol_%0d", i), eol_log[i], (i == 3 || i == 7 || i == 11));
                check($sformatf("raster_eof_%0d", i), eof_log[i], (i == 11));
            end
            check("raster_p6_x", x_log[6], 2);
            check("raster_p6_y", y_log[6], 1);
        end

        // frame_clr coinciding with the handshake of pixel (1,1).
        frame_clr = 1'b1;
        cycle();
        reset_trackers();
        auto_clr = 1'b1;
        for (int i = 0; i < 10; i++) load(16'($urandom_range(0, 65535)));
        drain(60, "clr");
        check("clr_hits", clr_hits, 1);
        check("clr_count", hs_cnt, 10);

        // Reset with one pixel buffered and one in flight.
        reset_trackers();
        for (int i = 0; i < 6; i++) load(16'h8421 + 16'(i * 16'h1111));
        repeat (3) cycle();
        rst = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_rden", fifo_rden, 0);
        exp_q.delete();
        mx = 0;
        my = 0;
        cycle();
        check("rst_mid_rden_held", fifo_rden, 0);
        rst = 1'b0;
        reset_trackers();
        drain(40, "rst_mid");
        check("rst_mid_count", hs_cnt, 3);
        if (x_log.size() > 0) begin
            check("rst_mid_first_xy", x_log[0] + y_log[0], 0);
            check("rst_mid_first_sof", sof_log[0], 1);
        end else begin
            check("rst_mid_no_pixel", 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
